// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC register, combinational fetch address and IF/ID pipeline register.
// Optional perf counters (fetch_count, stall_count) are built when FETCH_PERF_COUNTERS_EN is defined.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] A,
  input  logic [31:0] RD,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc_plus4_D,
  output logic        valid_D,
`ifdef FETCH_PERF_COUNTERS_EN
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
`endif
  output logic        misalign
);

  typedef enum logic [2:0] {
    ACT_ADVANCE,
    ACT_HOLD,
    ACT_FLUSH_HOLD,
    ACT_FLUSH_ADVANCE,
    ACT_REDIRECT
  } action_e;

  localparam logic [29:0] RESET_WORD = RESET_PC[31:2];

  // The PC is kept as a word address so its two low bits are zero by construction.
  logic [29:0] pc_word;
  logic [29:0] pc_word_inc;
  logic [29:0] pc_word_next;
  logic [31:0] instr_next;
  logic [31:0] pc_d_next;
  logic [31:0] pc_plus4_next;
  logic        valid_next;
  logic        misalign_next;
  logic        load_valid;
  action_e     action;

  assign A           = {pc_word, 2'b00};
  assign pc_word_inc = pc_word + 30'd1;

  always_comb begin
    action = ACT_ADVANCE;
    if (branch_taken) begin
      action = ACT_REDIRECT;
    end else if (stall) begin
      action = flush ? ACT_FLUSH_HOLD : ACT_HOLD;
    end else if (flush) begin
      action = ACT_FLUSH_ADVANCE;
    end
  end

  always_comb begin
    // NOTE: every signal gets a hold default first so no path through the case infers a latch.
    pc_word_next  = pc_word;
    instr_next    = instr_D;
    pc_d_next     = pc_D;
    pc_plus4_next = pc_plus4_D;
    valid_next    = valid_D;
    load_valid    = 1'b0;
    misalign_next = misalign | (branch_taken && (branch_target[1:0] != 2'b00));

    unique case (action)
      ACT_ADVANCE: begin
        pc_word_next  = pc_word_inc;
        instr_next    = RD;
        pc_d_next     = A;
        pc_plus4_next = {pc_word_inc, 2'b00};
        valid_next    = 1'b1;
        load_valid    = 1'b1;
      end
      ACT_HOLD: ;
      ACT_FLUSH_HOLD: begin
        instr_next = NOP_INSTR;
        valid_next = 1'b0;
      end
      ACT_FLUSH_ADVANCE: begin
        pc_word_next = pc_word_inc;
        instr_next   = NOP_INSTR;
        valid_next   = 1'b0;
      end
      ACT_REDIRECT: begin
        pc_word_next = branch_target[31:2];
        instr_next   = NOP_INSTR;
        valid_next   = 1'b0;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_word    <= RESET_WORD;
      instr_D    <= NOP_INSTR;
      pc_D       <= 32'h0;
      pc_plus4_D <= 32'h0;
      valid_D    <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      pc_word    <= pc_word_next;
      instr_D    <= instr_next;
      pc_D       <= pc_d_next;
      pc_plus4_D <= pc_plus4_next;
      valid_D    <= valid_next;
      misalign   <= misalign_next;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= 32'h0;
      stall_count <= 32'h0;
    end else begin
      if (load_valid && (fetch_count != 32'hFFFF_FFFF)) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (stall && !branch_taken && (stall_count != 32'hFFFF_FFFF)) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, meaning byte address loaded into PC on reset.
REQ-002 Parameter NOP_INSTR, default 32'hE1A00000, meaning instruction word inserted as a bubble.
REQ-003 clk  input  1  meaning single clock; all state updates on rising edge.
REQ-004 rst  input  1  meaning synchronous, active-high reset.
REQ-005 A  output  32  meaning fetch address (current PC) driven to instruction memory.
REQ-006 RD  input  32  meaning instruction word returned by instruction memory for A, same cycle (combinational read).
REQ-007 stall  input  1  meaning decode not ready; hold PC and IF/ID register.
REQ-008 flush  input  1  meaning discard the IF/ID contents (insert bubble).
REQ-009 branch_taken  input  1  meaning redirect fetch to branch_target.
REQ-010 branch_target  input  32  meaning redirect byte address.
REQ-011 instr_D  output  32  meaning registered instruction for decode.
REQ-012 pc_D  output  32  meaning registered address of instr_D.
REQ-013 pc_plus4_D  output  32  meaning pc_D + 4, registered.
REQ-014 valid_D  output  1  meaning instr_D holds a real fetched instruction.
REQ-015 misalign  output  1  meaning sticky flag: a redirect target had nonzero bits [1:0].

Function
REQ-016 A SHALL equal the PC register combinationally; there is no other address path.
REQ-017 Fetch-to-decode latency SHALL be one cycle: RD sampled at edge N appears on instr_D after edge N.
REQ-018 Per-edge priority SHALL be rst > branch_taken > stall > normal advance.
REQ-019 Normal advance (no stall/flush/branch): PC <= PC+4; instr_D <= RD; pc_D <= PC; pc_plus4_D <= PC+4; valid_D <= 1.
REQ-020 Stall (no branch): PC, instr_D, pc_D, pc_plus4_D and valid_D SHALL hold, unless flush is also asserted, in which case only the IF/ID register takes the bubble of REQ-022 and PC holds.
REQ-021 branch_taken: PC <= {branch_target[31:2],2'b00} regardless of stall; IF/ID SHALL take a bubble the same edge.
REQ-022 Bubble: instr_D <= NOP_INSTR, valid_D <= 0, pc_D and pc_plus4_D hold.
REQ-023 flush without stall or branch: IF/ID takes a bubble; PC <= PC+4.
REQ-024 misalign SHALL set on any edge with branch_taken=1 and branch_target[1:0]!=0, and clear only on reset.
REQ-025 PC arithmetic SHALL be modulo 2^32: PC 32'hFFFFFFFC advances to 32'h00000000 with no flag.
REQ-026 PC bits [1:0] SHALL always be 00.

Reset
REQ-027 On rst=1 at an edge: PC <= {RESET_PC[31:2],2'b00}, instr_D <= NOP_INSTR, pc_D <= 0, pc_plus4_D <= 0, valid_D <= 0, misalign <= 0, overriding all other inputs.
REQ-028 First valid instruction (address RESET_PC) SHALL appear on instr_D one edge after the first edge with rst=0 and no stall.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL discard the pending action entirely.

Configuration
REQ-030 Macro FETCH_PERF_COUNTERS_EN defined: outputs fetch_count[31:0] (increments on each edge where valid_D is loaded with 1) and stall_count[31:0] (increments on each edge where stall=1 and branch_taken=0) are present, both saturate at 32'hFFFFFFFF and reset to 0.
REQ-031 Macro undefined: these ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-032 Reset with RESET_PC=0, RD=32'hE3A00001, release rst -> A=0 at release; after the next edge instr_D=E3A00001, pc_D=0, pc_plus4_D=4, valid_D=1, A=4.
REQ-033 Stall for 3 cycles at PC=0x14 -> A stays 0x14; instr_D/pc_D/valid_D unchanged; with counters, stall_count=3.
REQ-034 branch_taken=1, branch_target=0x13C, stall=1 same cycle -> next A=0x13C, instr_D=E1A00000, valid_D=0, misalign=0.
REQ-035 branch_target=0x6D4A -> A=0x6D48, misalign=1, remains 1 after 5 further fetches until rst.
REQ-036 Run PC from 0xFFFFFFF8 for 3 edges -> A sequence 0xFFFFFFFC, 0x00000000, 0x00000004; pc_plus4_D for pc_D=0xFFFFFFFC equals 0.
REQ-037 flush=1 alone at PC=0x3C -> instr_D=NOP_INSTR, valid_D=0, next A=0x40; rst during that flush -> A=RESET_PC, valid_D=0.
